sdram_host_arbiter: RTL and testbench

//  Shares the single SDRAM controller host port (haddr/data_input/data_output/busy/
//  rd_enable/wr_enable) between two requesters, e.g. the DE0-Nano button/dip front end
//  and a pattern-test engine. Round-robin grant, one transaction in flight, registered

---
 rtl/sdram_host_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_sdram_host_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_host_arbiter.sv
// sdram_host_arbiter: round-robin share of the SDRAM controller host
// port between two requesters, one transaction in flight at a time.
module sdram_host_arbiter #(
  parameter int HADDR_WIDTH = 24,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req0_rd,
  input  logic                   req0_wr,
  input  logic [HADDR_WIDTH-1:0] req0_addr,
  input  logic [15:0]            req0_wdata,
  output logic                   req0_ack,
  output logic [15:0]            req0_rdata,
  output logic                   req0_err,
  input  logic                   req1_rd,
  input  logic                   req1_wr,
  input  logic [HADDR_WIDTH-1:0] req1_addr,
  input  logic [15:0]            req1_wdata,
  output logic                   req1_ack,
  output logic [15:0]            req1_rdata,
  output logic                   req1_err,
  output logic [HADDR_WIDTH-1:0] haddr,
  output logic [15:0]            data_input,
  input  logic [15:0]            data_output,
  input  logic                   busy,
  output logic                   rd_enable,
  output logic                   wr_enable
);

  localparam int TW = $clog2(ACK_TIMEOUT);
  localparam logic [TW-1:0] TMAX = TW'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_ACK,
    S_WAIT_DONE,
    S_RESP
  } state_t;

  state_t r_state;
  state_t w_next;

  logic                   r_last;
  logic                   r_grant;
  logic                   r_op_wr;
  logic                   r_err;
  logic                   r_rd_en;
  logic                   r_wr_en;
  logic [TW-1:0]          r_timer;
  logic [HADDR_WIDTH-1:0] r_haddr;
  logic [15:0]            r_din;
  logic [15:0]            r_rdata0;
  logic [15:0]            r_rdata1;

  logic                   w_act0;
  logic                   w_act1;
  logic                   w_sel;
  logic                   w_wr;
  logic [HADDR_WIDTH-1:0] w_addr;
  logic [15:0]            w_wdata;
  logic                   w_fire;
  logic                   w_tmo;
  logic                   w_fin;
  logic                   w_resp;

  assign w_act0 = req0_rd | req0_wr;
  assign w_act1 = req1_rd | req1_wr;

  // Pick the requester to serve; a tie goes to the one not served last.
  always_comb begin
    w_sel = w_act1;
    if (w_act0 && w_act1) w_sel = ~r_last;
    w_addr  = w_sel ? req1_addr  : req0_addr;
    w_wdata = w_sel ? req1_wdata : req0_wdata;
    w_wr    = w_sel ? req1_wr    : req0_wr;
  end

  // Next-state logic and the per-state events that the registers act on.
  always_comb begin
    w_next = r_state;
    w_fire = 1'b0;
    w_tmo  = 1'b0;
    w_fin  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!busy && (w_act0 || w_act1)) begin
          w_fire = 1'b1;
          w_next = S_ISSUE;
        end
      end
      S_ISSUE: w_next = S_WAIT_ACK;
      S_WAIT_ACK: begin
        if (busy) begin
          w_next = S_WAIT_DONE;
        end else if (r_timer == TMAX) begin
          w_tmo  = 1'b1;
          w_next = S_RESP;
        end
      end
      S_WAIT_DONE: begin
        if (!busy) begin
          w_fin  = 1'b1;
          w_next = S_RESP;
        end
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Grant bookkeeping and the latched command towards the controller.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last  <= 1'b1;
      r_grant <= 1'b0;
      r_op_wr <= 1'b0;
      r_haddr <= '0;
      r_din   <= '0;
      r_rd_en <= 1'b0;
      r_wr_en <= 1'b0;
    end else begin
      r_rd_en <= 1'b0;
      r_wr_en <= 1'b0;
      if (w_fire) begin
        r_last  <= w_sel;
        r_grant <= w_sel;
        r_op_wr <= w_wr;
        r_haddr <= w_addr;
        r_din   <= w_wdata;
        r_rd_en <= ~w_wr;
        r_wr_en <= w_wr;
      end
    end
  end

  // Wait-for-busy timer and the sticky timeout flag of this transaction.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_timer <= '0;
      r_err   <= 1'b0;
    end else begin
      if (r_state == S_ISSUE) begin
        r_timer <= '0;
      end else if (r_state == S_WAIT_ACK && !busy && !w_tmo) begin
        r_timer <= r_timer + 1'b1;
      end
      if (w_fire)     r_err <= 1'b0;
      else if (w_tmo) r_err <= 1'b1;
    end
  end

  // Read data return, captured on the edge where busy is seen low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else if (w_fin && !r_op_wr) begin
      if (r_grant) r_rdata1 <= data_output;
      else         r_rdata0 <= data_output;
    end
  end

  assign w_resp     = (r_state == S_RESP);
  assign req0_ack   = w_resp & ~r_grant;
  assign req1_ack   = w_resp & r_grant;
  assign req0_err   = w_resp & ~r_grant & r_err;
  assign req1_err   = w_resp & r_grant & r_err;
  assign req0_rdata = r_rdata0;
  assign req1_rdata = r_rdata1;
  assign haddr      = r_haddr;
  assign data_input = r_din;
  assign rd_enable  = r_rd_en;
  assign wr_enable  = r_wr_en;

endmodule

// File: tb/tb_sdram_host_arbiter.sv
// tb_sdram_host_arbiter: directed and random traffic from two
// requesters against a timeline model of the arbiter.
module tb_sdram_host_arbiter;

  localparam int AT = 8;

  typedef struct {
    bit          rd;
    bit          wr;
    logic [23:0] addr;
    logic [15:0] wdata;
    int          gap;
  } req_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_rd = 1'b0, req0_wr = 1'b0;
  logic        req1_rd = 1'b0, req1_wr = 1'b0;
  logic [23:0] req0_addr = '0, req1_addr = '0;
  logic [15:0] req0_wdata = '0, req1_wdata = '0;
  logic        req0_ack, req1_ack, req0_err, req1_err;
  logic [15:0] req0_rdata, req1_rdata;
  logic [23:0] haddr;
  logic [15:0] data_input;
  logic [15:0] data_output = '0;
  logic        busy = 1'b0;
  logic        rd_enable, wr_enable;

  sdram_host_arbiter #(
    .HADDR_WIDTH(24),
    .ACK_TIMEOUT(AT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_rd(req0_rd), .req0_wr(req0_wr),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req0_ack(req0_ack), .req0_rdata(req0_rdata),
    .req0_err(req0_err),
    .req1_rd(req1_rd), .req1_wr(req1_wr),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req1_ack(req1_ack), .req1_rdata(req1_rdata),
    .req1_err(req1_err),
    .haddr(haddr), .data_input(data_input),
    .data_output(data_output), .busy(busy),
    .rd_enable(rd_enable), .wr_enable(wr_enable)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  function automatic req_t mk(input bit rd, input bit wr,
                              input logic [23:0] a,
                              input logic [15:0] d, input int g);
    req_t r;
    r.rd = rd; r.wr = wr; r.addr = a; r.wdata = d; r.gap = g;
    return r;
  endfunction

  // Request queues drained by the two requester processes.
  req_t q0[$];
  req_t q1[$];

  task automatic set_req(input int n, input req_t r);
    if (n == 0) begin
      req0_rd = r.rd; req0_wr = r.wr;
      req0_addr = r.addr; req0_wdata = r.wdata;
    end else begin
      req1_rd = r.rd; req1_wr = r.wr;
      req1_addr = r.addr; req1_wdata = r.wdata;
    end
  endtask

  task automatic clr_req(input int n);
    if (n == 0) begin req0_rd = 0; req0_wr = 0; end
    else        begin req1_rd = 0; req1_wr = 0; end
  endtask

  function automatic logic ackv(input int n);
    return (n == 0) ? req0_ack : req1_ack;
  endfunction

  task automatic requester(input int n);
    req_t r;
    int   w;
    forever begin
      if ((n == 0 && q0.size() == 0) ||
          (n == 1 && q1.size() == 0)) begin
        clr_req(n);
        @(posedge clk); #1;
      end else begin
        if (n == 0) r = q0.pop_front();
        else        r = q1.pop_front();
        if (r.gap > 0) begin
          clr_req(n);
          repeat (r.gap) begin @(posedge clk); #1; end
        end
        set_req(n, r);
        w = 0;
        do begin
          @(posedge clk); #1; w++;
        end while (!ackv(n) && w < 3000);
        chk($sformatf("req%0d_ack_seen", n), 32'(ackv(n)), 1);
        @(posedge clk); #1;
      end
    end
  endtask

  initial requester(0);
  initial requester(1);

  // Controller model: plan chosen at the strobe, busy follows it.
  bit          p_act = 0, p_to = 0;
  int          p_s = 0, p_d = 1, p_l = 1;
  logic [15:0] p_data = '0;
  int          f_mode = 1;
  int          f_d = 1, f_l = 1;
  logic [15:0] f_data = '0;
  bit          refresh_en = 0;
  int          rf_left = 0;

  initial begin
    forever begin
      @(posedge clk); #1;
      data_output = 16'($urandom);
      if (p_act) begin
        busy = !p_to && cyc >= p_s + p_d && cyc < p_s + p_d + p_l;
        if (!p_to && cyc == p_s + p_d + p_l) data_output = p_data;
      end else if (rf_left > 0) begin
        busy = 1; rf_left--;
      end else if (refresh_en && !rd_enable && !wr_enable &&
                   $urandom_range(7) == 0) begin
        busy = 1; rf_left = $urandom_range(2);
      end else begin
        busy = 0;
      end
    end
  end

  // Reference timeline: grant, strobe cycle, ack cycle, returned data.
  bit          rst_e = 0;
  bit          m_txn = 0, m_who = 0, m_wr = 0, m_err = 0;
  bit          m_last = 1, m_bprev = 0;
  int          m_s = 0, m_ackc = -1, m_idle = 0;
  logic [23:0] m_addr = '0;
  logic [15:0] m_din = '0, m_rd0 = '0, m_rd1 = '0, m_data = '0;

  int obs_ack0 = 0, obs_ack1 = 0, obs_err = 0, obs_wr = 0;
  int obs_s = 0, obs_lat = 0;
  bit obs_lastwr = 0, obs_lastrd = 0;
  int obs_log[$];

  always @(negedge clk) begin : mdl
    logic e_a0, e_a1, e_e0, e_e1, e_rd, e_wr;
    logic a0, a1, sel;
    e_a0 = 0; e_a1 = 0; e_e0 = 0; e_e1 = 0;
    e_rd = 0; e_wr = 0;
    if (!rst_e) begin
      m_txn = 0; p_act = 0; m_last = 1;
      m_addr = '0; m_din = '0; m_rd0 = '0; m_rd1 = '0;
      m_idle = cyc;
    end else if (m_txn) begin
      if (cyc == m_s) begin e_rd = !m_wr; e_wr = m_wr; end
      if (cyc == m_ackc) begin
        if (m_who) begin e_a1 = 1; e_e1 = m_err; end
        else       begin e_a0 = 1; e_e0 = m_err; end
        if (!m_err && !m_wr) begin
          if (m_who) m_rd1 = m_data;
          else       m_rd0 = m_data;
        end
        m_txn = 0; p_act = 0; m_idle = cyc + 1;
      end
    end
    chk("req0_ack", 32'(req0_ack), 32'(e_a0));
    chk("req1_ack", 32'(req1_ack), 32'(e_a1));
    chk("req0_err", 32'(req0_err), 32'(e_e0));
    chk("req1_err", 32'(req1_err), 32'(e_e1));
    chk("rd_enable", 32'(rd_enable), 32'(e_rd));
    chk("wr_enable", 32'(wr_enable), 32'(e_wr));
    chk("haddr", 32'(haddr), 32'(m_addr));
    chk("data_input", 32'(data_input), 32'(m_din));
    chk("req0_rdata", 32'(req0_rdata), 32'(m_rd0));
    chk("req1_rdata", 32'(req1_rdata), 32'(m_rd1));
    if (rst_e && (rd_enable || wr_enable)) begin
      chk("no_strobe_while_busy", 32'(m_bprev), 0);
      obs_s = cyc;
      obs_lastwr = wr_enable;
      obs_lastrd = rd_enable;
      if (wr_enable) obs_wr++;
    end
    if (req0_ack) begin obs_ack0++; obs_log.push_back(0); end
    if (req1_ack) begin obs_ack1++; obs_log.push_back(1); end
    if (req0_err || req1_err) obs_err++;
    if (req0_ack || req1_ack) obs_lat = cyc - obs_s;
    if (rst_e && m_txn && cyc == m_s) begin
      p_to = (f_mode == 2) ||
             (f_mode == 0 && $urandom_range(9) == 0);
      if (f_mode == 1) begin
        p_d = f_d; p_l = f_l; p_data = f_data;
      end else begin
        p_d = ($urandom_range(3) == 0) ? AT : $urandom_range(AT, 1);
        p_l = $urandom_range(6, 1);
        p_data = 16'($urandom);
      end
      p_s = cyc; p_act = 1;
      m_data = p_data; m_err = p_to;
      m_ackc = p_to ? cyc + 1 + AT : cyc + p_d + p_l + 1;
    end
    a0 = req0_rd | req0_wr;
    a1 = req1_rd | req1_wr;
    if (rst_n && !m_txn && cyc >= m_idle && !busy && (a0 || a1)) begin
      sel = (a0 && a1) ? !m_last : a1;
      m_who = sel; m_last = sel;
      m_wr   = sel ? req1_wr : req0_wr;
      m_addr = sel ? req1_addr : req0_addr;
      m_din  = sel ? req1_wdata : req0_wdata;
      m_txn = 1; m_s = cyc + 1; m_ackc = -1;
    end
    m_bprev = busy;
    rst_e = rst_n;
  end

  task automatic wait_acks(input int tgt);
    int w;
    w = 0;
    while (obs_ack0 + obs_ack1 < tgt && w < 10000) begin
      @(posedge clk); w++;
    end
    chk("acks_reached", 32'(obs_ack0 + obs_ack1 >= tgt), 1);
    repeat (3) @(negedge clk);
  endtask

  initial begin : main
    int b0, b1, be, lg, w, k;
    int ord[6];
    ord = '{0, 1, 0, 1, 0, 1};
    // T1 + T2: write held through reset, served after release
    f_mode = 1; f_d = 1; f_l = 5;
    q0.push_back(mk(0, 1, 24'h000123, 16'hA55A, 0));
    repeat (3) begin
      @(negedge clk);
      chk("t1_strobes", 32'({rd_enable, wr_enable}), 0);
      chk("t1_ack", 32'({req0_ack, req1_ack}), 0);
      chk("t1_haddr", 32'(haddr), 0);
    end
    @(posedge clk); #1 rst_n = 1;
    wait_acks(1);
    chk("t2_haddr", 32'(haddr), 32'h000123);
    chk("t2_data_input", 32'(data_input), 32'hA55A);
    chk("t2_wr_strobes", 32'(obs_wr), 1);
    chk("t2_ack_latency", 32'(obs_lat), 7);
    chk("t2_ack0_count", 32'(obs_ack0), 1);
    // T3: read on requester 1
    f_d = 2; f_l = 3; f_data = 16'hBEEF;
    q1.push_back(mk(1, 0, 24'h0000FF, 16'h0000, 0));
    wait_acks(2);
    chk("t3_req1_rdata", 32'(req1_rdata), 32'hBEEF);
    chk("t3_req0_rdata", 32'(req0_rdata), 0);
    chk("t3_haddr", 32'(haddr), 32'h0000FF);
    chk("t3_rd_strobe", 32'(obs_lastrd), 1);
    chk("t3_ack_latency", 32'(obs_lat), 6);
    // T4: both requesters held back to back
    f_mode = 3;
    lg = obs_log.size();
    for (int i = 0; i < 3; i++) begin
      q0.push_back(mk(0, 1, 24'(16 + i), 16'(i), 0));
      q1.push_back(mk(1, 0, 24'(32 + i), 16'(i), 0));
    end
    wait_acks(8);
    for (int i = 0; i < 6; i++)
      chk($sformatf("t4_order_%0d", i),
          32'(obs_log[lg + i]), 32'(ord[i]));
    // T5: read and write together -> write
    f_mode = 1; f_d = 1; f_l = 2;
    q0.push_back(mk(1, 1, 24'h00ABCD, 16'h1357, 0));
    wait_acks(9);
    chk("t5_wr_strobe", 32'(obs_lastwr), 1);
    chk("t5_rd_strobe", 32'(obs_lastrd), 0);
    chk("t5_data_input", 32'(data_input), 32'h1357);
    // T6: busy never rises -> ack with err, rdata kept
    f_mode = 2; be = obs_err;
    q0.push_back(mk(1, 0, 24'h000777, 16'h0F0F, 0));
    wait_acks(10);
    chk("t6_err_count", 32'(obs_err - be), 1);
    chk("t6_ack_latency", 32'(obs_lat), 32'(AT + 1));
    chk("t6_req0_rdata", 32'(req0_rdata), 0);
    f_mode = 1; f_d = 3; f_l = 1; f_data = 16'h5A5A;
    q1.push_back(mk(1, 0, 24'h000010, 16'h0000, 0));
    wait_acks(11);
    chk("t6_next_rdata", 32'(req1_rdata), 32'h5A5A);
    chk("t6_next_no_err", 32'(obs_err - be), 1);
    // T7: reset while the controller is busy
    f_d = 1; f_l = 20;
    b0 = obs_ack0; b1 = obs_ack1;
    q0.push_back(mk(0, 1, 24'h000321, 16'h7777, 0));
    w = 0;
    while (!busy && w < 100) begin @(posedge clk); #2; w++; end
    chk("t7_busy_seen", 32'(busy), 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 0;
    f_l = 2;
    q1.push_back(mk(1, 0, 24'h000042, 16'h0000, 0));
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    lg = obs_log.size();
    wait_acks(obs_ack0 + obs_ack1 + 2);
    chk("t7_ack0_once", 32'(obs_ack0 - b0), 1);
    chk("t7_ack1_once", 32'(obs_ack1 - b1), 1);
    chk("t7_first_after_reset", 32'(obs_log[lg]), 0);
    chk("t7_second_after_reset", 32'(obs_log[lg + 1]), 1);
    chk("t7_haddr", 32'(haddr), 32'h000042);
    // Random traffic with refresh-style busy in idle
    f_mode = 0; refresh_en = 1;
    b0 = obs_ack0 + obs_ack1;
    for (int i = 0; i < 30; i++) begin
      k = $urandom_range(2);
      q0.push_back(mk(k != 1, k != 0, 24'($urandom),
                      16'($urandom), $urandom_range(4)));
      k = $urandom_range(2);
      q1.push_back(mk(k != 1, k != 0, 24'($urandom),
                      16'($urandom), $urandom_range(4)));
    end
    wait_acks(b0 + 60);
    refresh_en = 0;
    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
